// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and defaults: TX state encoding, word-length codes, FIFO/oversample defaults.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_e;

  localparam logic [1:0] WLEN_5 = 2'b00;
  localparam logic [1:0] WLEN_6 = 2'b01;
  localparam logic [1:0] WLEN_7 = 2'b10;
  localparam logic [1:0] WLEN_8 = 2'b11;

  localparam int UART_FIFO_DEPTH = 16;
  localparam int UART_OVERSAMPLE = 16;

  // Selects the data bits that are actually transmitted for a given word length.
  function automatic logic [7:0] wlen_mask(input logic [1:0] w);
    return 8'hFF >> (2'd3 - w);
  endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// rtl/uart_tx_engine_if.sv - CPU-side write handshake into the UART TX FIFO.
interface uart_tx_engine_if;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock FIFO with flush and occupancy counter, shared by the TX and RX engines.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  input  logic                     clr,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  // A flush wins over any push or pop issued in the same cycle.
  assign push_ok  = push && !full && !clr;
  assign pop_ok   = pop && !empty && !clr;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_engine.sv
// rtl/uart_tx_engine.sv - buffered 16550-class serial transmitter with status and empty interrupt.
// Parity stage is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = UART_FIFO_DEPTH,
  parameter int DIV_WIDTH  = 16,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DIV_WIDTH-1:0]        divisor,
  input  logic [1:0]                  wlen,
  input  logic                        stop2,
  input  logic                        par_en,
  input  logic                        par_even,
  input  logic                        par_stick,
  input  logic                        break_en,
  input  logic                        fifo_clr,
  uart_tx_engine_if.slave             wr,
  output logic                        tx_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        thr_empty,
  output logic                        tx_empty,
  output logic                        irq_o
);
  localparam int LW   = $clog2(FIFO_DEPTH) + 1;
  localparam int PH_W = $clog2(OVERSAMPLE) + 1;

  uart_tx_state_e       state_q, state_d;
  logic [7:0]           head;
  logic [7:0]           shift_q;
  logic [2:0]           bit_idx_q;
  logic [2:0]           last_idx;
  logic [1:0]           wlen_q;
  logic                 stop2_q;
  logic                 stop_cnt_q;
  logic [DIV_WIDTH-1:0] presc_q;
  logic [PH_W-1:0]      phase_q;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 start_frame;
  logic                 push_ok;
  logic                 tick;
  logic                 bit_end;
  logic                 line_d;

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr.wr_valid),
    .push_data (wr.wr_data),
    .pop       (start_frame),
    .pop_data  (head),
    .clr       (fifo_clr),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign wr.wr_ready = !fifo_full;
  assign push_ok     = wr.wr_valid && !fifo_full && !fifo_clr;
  assign thr_empty   = fifo_empty;
  assign tx_empty    = fifo_empty && (state_q == IDLE);
  assign start_frame = (state_q == IDLE) && !fifo_empty && (divisor != '0);
  assign tick        = (divisor != '0) && (presc_q >= divisor - DIV_WIDTH'(1));
  assign bit_end     = tick && (phase_q == PH_W'(OVERSAMPLE - 1));
  assign last_idx    = 3'd4 + {1'b0, wlen_q};

`ifdef UART_TX_PARITY_EN
  logic par_en_q;
  logic par_bit_q;
  logic par_calc;

  always_comb begin
    par_calc = ^(head & wlen_mask(wlen));
    if (par_stick)      par_calc = ~par_even;
    else if (!par_even) par_calc = ~par_calc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else if (start_frame) begin
      par_en_q  <= par_en;
      par_bit_q <= par_calc;
    end
  end
`else
  logic unused_par;
  assign unused_par = par_en ^ par_even ^ par_stick;
`endif

  always_comb begin
    state_d = state_q;
    line_d  = 1'b1;
    unique case (state_q)
      IDLE:   if (start_frame) state_d = START;
      START:  if (bit_end) state_d = DATA;
      DATA: begin
        if (bit_end && (bit_idx_q == last_idx)) begin
`ifdef UART_TX_PARITY_EN
          state_d = par_en_q ? PARITY : STOP;
`else
          state_d = STOP;
`endif
        end
      end
      PARITY: if (bit_end) state_d = STOP;
      STOP:   if (bit_end && (!stop2_q || stop_cnt_q)) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // tx_o is registered, so the line level is derived from where the FSM is heading.
    unique case (state_d)
      START:   line_d = 1'b0;
      DATA:    line_d = (state_q == DATA && bit_end) ? shift_q[1] : shift_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  line_d = par_bit_q;
`endif
      default: line_d = 1'b1;
    endcase
    if (break_en) line_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tx_o       <= 1'b1;
      irq_o      <= 1'b0;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      wlen_q     <= '0;
      stop2_q    <= 1'b0;
      stop_cnt_q <= 1'b0;
      presc_q    <= '0;
      phase_q    <= '0;
    end else begin
      state_q <= state_d;
      tx_o    <= line_d;
      irq_o   <= start_frame && (fifo_clr || (fifo_level == LW'(1) && !push_ok));
      if (start_frame) begin
        shift_q    <= head;
        wlen_q     <= wlen;
        stop2_q    <= stop2;
        bit_idx_q  <= '0;
        stop_cnt_q <= 1'b0;
        presc_q    <= '0;
        phase_q    <= '0;
      end else if (state_q != IDLE) begin
        if (tick) begin
          presc_q <= '0;
          phase_q <= bit_end ? '0 : phase_q + PH_W'(1);
        end else begin
          presc_q <= presc_q + DIV_WIDTH'(1);
        end
        if (bit_end && state_q == DATA) begin
          shift_q   <= shift_q >> 1;
          bit_idx_q <= bit_idx_q + 3'd1;
        end
        if (bit_end && state_q == STOP) stop_cnt_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_engine.sv
// tb/tb_uart_tx_engine.sv - scoreboard bench for uart_tx_engine; line monitor decodes frames against queued expectations.
module tb_uart_tx_engine;
  import uart_pkg::*;

  localparam int BIT = 16;

`ifdef UART_TX_PARITY_EN
  localparam bit HP = 1'b1;
`else
  localparam bit HP = 1'b0;
`endif

  typedef struct {
    logic [15:0] bits;
    int          n;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] divisor;
  logic [1:0]  wlen;
  logic        stop2, par_en, par_even, par_stick, break_en, fifo_clr;
  logic        tx_o;
  logic [4:0]  fifo_level;
  logic        thr_empty, tx_empty, irq_o;

  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;
  int     irq_cnt = 0;
  int     nframes = 0;
  bit     mon_en = 1'b0;
  frame_t exp_q[$];

  uart_tx_engine_if wr_if ();

  uart_tx_engine dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .divisor    (divisor),
    .wlen       (wlen),
    .stop2      (stop2),
    .par_en     (par_en),
    .par_even   (par_even),
    .par_stick  (par_stick),
    .break_en   (break_en),
    .fifo_clr   (fifo_clr),
    .wr         (wr_if),
    .tx_o       (tx_o),
    .fifo_level (fifo_level),
    .thr_empty  (thr_empty),
    .tx_empty   (tx_empty),
    .irq_o      (irq_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (irq_o) irq_cnt <= irq_cnt + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic frame_t mk(input logic [7:0] d, input int nb, input bit hp, input bit pb, input int ns);
    frame_t f;
    int     k;
    f.bits = '0;
    k = 1;
    for (int i = 0; i < nb; i++) begin f.bits[k] = d[i]; k++; end
    if (hp) begin f.bits[k] = pb; k++; end
    for (int i = 0; i < ns; i++) begin f.bits[k] = 1'b1; k++; end
    f.n = k;
    return f;
  endfunction

  task automatic expect_frame(input logic [7:0] d, input int nb, input bit hp, input bit pb, input int ns);
    exp_q.push_back(mk(d, nb, hp, pb, ns));
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = d;
    step();
    wr_if.wr_valid = 1'b0;
  endtask

  task automatic wait_fall(output int s);
    int n = 0;
    while (tx_o !== 1'b0 && n < 400) begin step(); n++; end
    chk("fall_timeout", tx_o, 0);
    s = cyc;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (tx_empty !== 1'b1 && n < limit) begin step(); n++; end
    chk("idle_timeout", tx_empty, 1);
  endtask

  // Monitor: a falling edge from idle starts a frame, sampled mid-bit.
  initial begin : monitor
    frame_t      e;
    logic [15:0] got;
    logic        prev;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && prev && !tx_o) begin
        if (exp_q.size() == 0) begin
          e.bits = 16'hFFFF;
          e.n    = 10;
        end else begin
          e = exp_q.pop_front();
        end
        got = '0;
        repeat (BIT / 2 - 1) @(negedge clk);
        for (int i = 0; i < e.n; i++) begin
          got[i] = tx_o;
          if (i != e.n - 1) repeat (BIT) @(negedge clk);
        end
        nframes++;
        chk($sformatf("frame%0d", nframes), got, e.bits);
      end
      prev = tx_o;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] tab [16] = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h80, 8'h3C, 8'hC3,
                           8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
  logic [2:0] par_tab [4] = '{3'b100, 3'b001, 3'b110, 3'b011};

  initial begin : main
    int s, n, base, hi, lo;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_data  = 8'h00;
    divisor = 16'd1; wlen = WLEN_8; stop2 = 1'b0;
    par_en = 1'b0; par_even = 1'b0; par_stick = 1'b0;
    break_en = 1'b0; fifo_clr = 1'b0;

    #2 rst_n = 1'b0;
    #20;
    chk("rst_tx_o", tx_o, 1);
    chk("rst_wr_ready", wr_if.wr_ready, 1);
    chk("rst_level", fifo_level, 0);
    chk("rst_thr_empty", thr_empty, 1);
    chk("rst_tx_empty", tx_empty, 1);
    chk("rst_irq", irq_o, 0);
    step();
    rst_n = 1'b1;
    mon_en = 1'b1;
    step();

    // 8N1 0x55: latency, bit period, TEMT timing, single irq
    base = irq_cnt;
    expect_frame(8'h55, 8, 0, 0, 1);
    write_byte(8'h55);
    chk("lat_w1", tx_o, 1);
    step();
    chk("lat_w2", tx_o, 0);
    n = 0;
    while (tx_o == 1'b0 && n < 40) begin step(); n++; end
    chk("start_len", n, 16);
    repeat (143) step();
    chk("temt_pre", tx_empty, 0);
    chk("stop_line", tx_o, 1);
    step();
    chk("temt_rise", tx_empty, 1);
    chk("irq_8n1", irq_cnt - base, 1);

    // Parity variants on 0xA5: {par_even, par_stick, expected bit}
    par_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      par_even  = par_tab[i][2];
      par_stick = par_tab[i][1];
      expect_frame(8'hA5, 8, HP, par_tab[i][0], 1);
      write_byte(8'hA5);
      wait_idle(400);
    end
    par_en = 1'b0; par_even = 1'b0; par_stick = 1'b0;

    // 5 data bits, two stop bits
    wlen = WLEN_5; stop2 = 1'b1;
    expect_frame(8'hE3, 5, 0, 0, 2);
    write_byte(8'hE3);
    wait_fall(s);
    repeat (95) step();
    chk("w5_last_data", tx_o, 0);
    step();
    chk("w5_stop_begin", tx_o, 1);
    repeat (31) step();
    chk("w5_stop_temt_pre", tx_empty, 0);
    step();
    chk("w5_stop_temt", tx_empty, 1);
    wlen = WLEN_8; stop2 = 1'b0;

    // FIFO full with divisor=0, then drain back-to-back
    divisor = 16'd0;
    for (int i = 0; i < 16; i++) begin
      expect_frame(tab[i], 8, 0, 0, 1);
      write_byte(tab[i]);
    end
    chk("full_level", fifo_level, 16);
    chk("full_ready", wr_if.wr_ready, 0);
    chk("full_thr", thr_empty, 0);
    write_byte(8'hEE);
    chk("full_drop", fifo_level, 16);
    chk("div0_idle", tx_o, 1);
    base = irq_cnt;
    divisor = 16'd1;
    wait_fall(s);
    repeat (160) step();
    chk("b2b_pop", tx_o, 1);
    step();
    chk("b2b_start", tx_o, 0);
    wait_idle(16 * 170);
    chk("irq_drain", irq_cnt - base, 1);

    // Break mid-frame
    mon_en = 1'b0;
    step();
    write_byte(8'hFF);
    wait_fall(s);
    repeat (40) step();
    break_en = 1'b1;
    hi = 0;
    repeat (30) begin step(); if (tx_o) hi++; end
    chk("brk_low", hi, 0);
    break_en = 1'b0;
    step();
    chk("brk_release", tx_o, 1);
    while (cyc < s + 159) step();
    chk("brk_sched_pre", tx_empty, 0);
    step();
    chk("brk_sched", tx_empty, 1);
    step();
    mon_en = 1'b1;
    step();

    // Flush with 5 queued: only the in-flight frame completes
    expect_frame(8'h3C, 8, 0, 0, 1);
    write_byte(8'h3C);
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    write_byte(8'h44);
    write_byte(8'h66);
    chk("clr_level_pre", fifo_level, 5);
    fifo_clr = 1'b1;
    step();
    fifo_clr = 1'b0;
    chk("clr_level", fifo_level, 0);
    chk("clr_thr", thr_empty, 1);
    wait_idle(400);

    // Reset during DATA
    mon_en = 1'b0;
    step();
    write_byte(8'h00);
    write_byte(8'h00);
    write_byte(8'h81);
    wait_fall(s);
    repeat (40) step();
    chk("pre_rst_data", tx_o, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_tx_o", tx_o, 1);
    chk("arst_level", fifo_level, 0);
    chk("arst_thr", thr_empty, 1);
    chk("arst_temt", tx_empty, 1);
    chk("arst_ready", wr_if.wr_ready, 1);
    chk("arst_irq", irq_o, 0);
    step();
    step();
    rst_n = 1'b1;
    lo = 0;
    repeat (400) begin step(); if (!tx_o) lo++; end
    chk("no_resume", lo, 0);
    chk("post_rst_level", fifo_level, 0);

    chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
